// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the unified memory port of mem_port_arbiter.
// The slave modport is the arbiter. The master modport is the pipeline and memory around it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_f;
    logic              stall_m;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_be, mem_addr,
               mem_wdata, stall_f, stall_m, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_be, mem_addr,
               mem_wdata, stall_f, stall_m, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Each access is a registered request/ack transaction followed by a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusyD, StBusyI, StDone} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 1 = data was granted last
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              timeout_hit;
    logic [DATA_W-1:0] rdata_cap;

    assign timeout_hit = !bus.mem_ack && (cnt_q == 8'(TIMEOUT - 1));
    assign rdata_cap   = bus.mem_ack ? bus.mem_rdata : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Data has priority, but yields to fetch right after its own grant.
                if (bus.dm_req && (!bus.if_req || !last_grant_q)) begin
                    state_d      = StBusyD;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.dm_we;
                    mem_be_d     = bus.dm_be;
                    mem_addr_d   = bus.dm_addr;
                    mem_wdata_d  = bus.dm_wdata;
                end else if (bus.if_req) begin
                    state_d      = StBusyI;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = bus.if_addr;
                end
            end
            StBusyD, StBusyI: begin
                if (bus.mem_ack || timeout_hit) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    if (timeout_hit) begin
                        err_d = 1'b1;
                    end
                    if (state_q == StBusyI) begin
                        if_rdata_d = rdata_cap;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = rdata_cap;
                        end
                        dm_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.err       = err_q;
    // Stalls release in the ready cycle so the pipeline advances at its closing edge.
    assign bus.stall_f   = bus.if_req & ~if_ready_q;
    assign bus.stall_m   = bus.dm_req & ~dm_ready_q;
endmodule
